// File: rtl/cpu_dbg_pkg.sv
// rtl/cpu_dbg_pkg.sv - shared state type and seven-segment constants for the debug monitor
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP,
    BRK
  } dbg_state_t;

  // Active-low segments, bit order g..a
  localparam logic [6:0] BLANK_SEG = 7'h7F;

  localparam logic [6:0] HEX_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_digit_enc.sv
// rtl/hex_digit_enc.sv - one nibble to active-low seven-segment pattern, with blanking
module hex_digit_enc (
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);
  import cpu_dbg_pkg::*;

  // Blank overrides the nibble so out-of-range digit positions stay dark
  always_comb begin
    seg = blank ? BLANK_SEG : HEX_LUT[nibble];
  end

endmodule

// File: rtl/cpu_debug_monitor.sv
// rtl/cpu_debug_monitor.sv - run/step/breakpoint clock gating and snapshot readout; DBG_BREAKPOINT_EN enables the PC breakpoint
module cpu_debug_monitor #(
  parameter int DATA_W        = 32,
  parameter int NUM_CH        = 16,
  parameter int CYC_PER_INSTR = 7,
  parameter int HEX_DIGITS    = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run_mode,
  input  logic                       step_req,
  input  logic [$clog2(NUM_CH)-1:0]  ch_sel,
  input  logic                       disp_sel,
  input  logic                       page,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  input  logic [DATA_W-1:0]          status_in,
  input  logic [DATA_W-1:0]          pc_in,
  input  logic [DATA_W-1:0]          brk_addr,
  input  logic                       brk_arm,
  output logic                       cpu_en,
  output logic                       instr_done,
  output logic                       halted,
  output logic [HEX_DIGITS*7-1:0]    hex_out,
  output logic [9:0]                 led_out
);
  import cpu_dbg_pkg::*;

  localparam int SEL_W = $clog2(NUM_CH);
  localparam int CNT_W = (CYC_PER_INSTR > 1) ? $clog2(CYC_PER_INSTR) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYC_PER_INSTR - 1);
  localparam bit ONE_CYC = (CYC_PER_INSTR == 1);
  localparam int NIBBLES = DATA_W / 4;

  dbg_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              brk_hit;
  logic              stopped;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] snap_ch;
  logic [DATA_W-1:0] snap_st;
  logic [DATA_W-1:0] disp_word;
  logic [HEX_DIGITS*7-1:0] seg_all;

  assign cnt_nxt = cnt + 1'b1;
  assign stopped = (state == IDLE) || (state == BRK);

`ifdef DBG_BREAKPOINT_EN
  // Breakpoint only matters at an instruction boundary, where the FSM samples it
  assign brk_hit = brk_arm && (pc_in == brk_addr);
`else
  logic unused_brk;
  assign brk_hit    = 1'b0;
  assign unused_brk = ^{brk_addr, brk_arm, pc_in};
`endif

  // Control FSM: the cycle counter only runs while the core is enabled, and the
  // run/stop decision is made only at cnt == LAST_CNT so instructions never split
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cpu_en     <= 1'b0;
      instr_done <= 1'b0;
      halted     <= 1'b1;
    end else begin
      case (state)
        IDLE, BRK: begin
          if ((state == IDLE && run_mode) || step_req) begin
            state      <= (state == IDLE && run_mode) ? RUN : STEP;
            cnt        <= '0;
            cpu_en     <= 1'b1;
            instr_done <= ONE_CYC;
            halted     <= 1'b0;
          end
        end
        RUN, STEP: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (!brk_hit && state == RUN && run_mode) begin
              instr_done <= ONE_CYC;
            end else begin
              state      <= brk_hit ? BRK : IDLE;
              cpu_en     <= 1'b0;
              instr_done <= 1'b0;
              halted     <= 1'b1;
            end
          end else begin
            cnt        <= cnt_nxt;
            instr_done <= (cnt_nxt == LAST_CNT);
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          cpu_en     <= 1'b0;
          instr_done <= 1'b0;
          halted     <= 1'b1;
        end
      endcase
    end
  end

  // Snapshots: capture at each boundary; while stopped, follow a channel reselect
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= '0;
      snap_ch <= '0;
      snap_st <= '0;
    end else begin
      sel_q <= ch_sel;
      if (instr_done) begin
        snap_ch <= ch_data[int'(ch_sel)*DATA_W +: DATA_W];
        snap_st <= status_in;
      end else if (stopped && (ch_sel != sel_q)) begin
        snap_ch <= ch_data[int'(ch_sel)*DATA_W +: DATA_W];
      end
    end
  end

  // Word being displayed follows the selects combinationally; outputs are registered below
  always_comb begin
    disp_word = disp_sel ? snap_st : snap_ch;
  end

  for (genvar d = 0; d < HEX_DIGITS; d++) begin : g_digit
    logic [3:0] nib_lo;
    logic [3:0] nib_hi;
    logic       blank_lo;
    logic       blank_hi;

    if (d < NIBBLES) begin : g_lo
      assign nib_lo   = disp_word[d*4 +: 4];
      assign blank_lo = 1'b0;
    end else begin : g_lo_blank
      assign nib_lo   = 4'h0;
      assign blank_lo = 1'b1;
    end

    if (HEX_DIGITS + d < NIBBLES) begin : g_hi
      assign nib_hi   = disp_word[(HEX_DIGITS+d)*4 +: 4];
      assign blank_hi = 1'b0;
    end else begin : g_hi_blank
      assign nib_hi   = 4'h0;
      assign blank_hi = 1'b1;
    end

    hex_digit_enc u_enc (
      .nibble (page ? nib_hi : nib_lo),
      .blank  (page ? blank_hi : blank_lo),
      .seg    (seg_all[d*7 +: 7])
    );
  end

  // Register the board-facing readout so it changes one cycle after its sources
  always_ff @(posedge clk) begin
    if (rst) begin
      hex_out <= {HEX_DIGITS{7'h40}};
      led_out <= '0;
    end else begin
      hex_out <= seg_all;
      led_out <= snap_ch[9:0];
    end
  end

endmodule

// File: tb/tb_cpu_debug_monitor.sv
// tb/tb_cpu_debug_monitor.sv - scoreboard bench for cpu_debug_monitor
module tb_cpu_debug_monitor;

  logic         clk = 1'b0;
  logic         rst;
  logic         run_mode;
  logic         step_req;
  logic [3:0]   ch_sel;
  logic         disp_sel;
  logic         page;
  logic [511:0] ch_data;
  logic [31:0]  status_in;
  logic [31:0]  pc_in;
  logic [31:0]  brk_addr;
  logic         brk_arm;
  logic         cpu_en;
  logic         instr_done;
  logic         halted;
  logic [41:0]  hex_out;
  logic [9:0]   led_out;

  cpu_debug_monitor #(
    .DATA_W(32), .NUM_CH(16), .CYC_PER_INSTR(7), .HEX_DIGITS(6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run_mode   (run_mode),
    .step_req   (step_req),
    .ch_sel     (ch_sel),
    .disp_sel   (disp_sel),
    .page       (page),
    .ch_data    (ch_data),
    .status_in  (status_in),
    .pc_in      (pc_in),
    .brk_addr   (brk_addr),
    .brk_arm    (brk_arm),
    .cpu_en     (cpu_en),
    .instr_done (instr_done),
    .halted     (halted),
    .hex_out    (hex_out),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_EN = 0, S_DONE = 1, S_HALT = 2, S_HEX = 3, S_LED = 4;

  typedef struct {
    string       name;
    int          id;
    int          at;
    logic [63:0] val;
  } chk_t;

  chk_t chk_q[$];
  int   done_q[$];
  int   total = 0;
  int   bad = 0;
  bit   fin = 1'b0;

  task automatic expect_sig(input string name, input int id, input int at, input logic [63:0] val);
    chk_t c;
    c.name = name;
    c.id   = id;
    c.at   = at;
    c.val  = val;
    chk_q.push_back(c);
  endtask

  task automatic expect_done(input int at);
    done_q.push_back(at);
  endtask

  function automatic logic [63:0] sig_val(input int id);
    case (id)
      S_EN:    return 64'(cpu_en);
      S_DONE:  return 64'(instr_done);
      S_HALT:  return 64'(halted);
      S_HEX:   return 64'(hex_out);
      default: return 64'(led_out);
    endcase
  endfunction

  // Monitor: the only process that compares and counts
  always @(negedge clk) begin
    while (done_q.size() > 0 && done_q[0] < cyc) begin
      total++;
      bad++;
      $display("FAIL instr_done missing: got none at cycle %0d, required pulse", done_q[0]);
      void'(done_q.pop_front());
    end
    if (instr_done === 1'b1) begin
      total++;
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        void'(done_q.pop_front());
      end else begin
        bad++;
        $display("FAIL instr_done unexpected at cycle %0d: got 1 required 0", cyc);
      end
    end
    for (int i = chk_q.size() - 1; i >= 0; i--) begin
      if (chk_q[i].at == cyc) begin
        total++;
        if (sig_val(chk_q[i].id) !== chk_q[i].val) begin
          bad++;
          $display("FAIL %s at cycle %0d: got %0h required %0h",
                   chk_q[i].name, cyc, sig_val(chk_q[i].id), chk_q[i].val);
        end
        chk_q.delete(i);
      end
    end
    if (fin) begin
      if (done_q.size() > 0 || chk_q.size() > 0) begin
        total++;
        bad++;
        $display("FAIL leftover expectations: got %0d pending required 0", done_q.size() + chk_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus required finish");
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t;
    rst       = 1'b1;
    run_mode  = 1'b0;
    step_req  = 1'b0;
    ch_sel    = 4'd0;
    disp_sel  = 1'b0;
    page      = 1'b0;
    status_in = 32'h8000_0000;
    pc_in     = 32'h0;
    brk_addr  = 32'h0;
    brk_arm   = 1'b0;
    for (int k = 0; k < 16; k++) ch_data[k*32 +: 32] = 32'h0101_0101 * (k + 1);
    ch_data[3*32 +: 32] = 32'h0000_0055;

    // Reset and three idle cycles
    @(negedge clk);
    t = cyc;
    expect_sig("rst_cpu_en", S_EN, t + 1, 64'd0);
    expect_sig("rst_halted", S_HALT, t + 1, 64'd1);
    wait_cyc(2);
    rst = 1'b0;
    t = cyc;
    expect_sig("idle_cpu_en", S_EN, t + 3, 64'd0);
    expect_sig("idle_halted", S_HALT, t + 3, 64'd1);
    expect_sig("idle_hex", S_HEX, t + 3, 64'({6{7'h40}}));
    expect_sig("idle_led", S_LED, t + 3, 64'd0);
    wait_cyc(4);

    // Reselect while halted re-latches the channel
    ch_sel = 4'd3;
    t = cyc;
    expect_sig("resel_led", S_LED, t + 2, 64'h055);
    expect_sig("resel_hex", S_HEX, t + 2, 64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h12, 7'h12}));
    wait_cyc(3);
    ch_data[3*32 +: 32] = 32'h00AB_CDEF;
    wait_cyc(3);

    // Single step
    t = cyc;
    step_req = 1'b1;
    expect_sig("step_hold_led", S_LED, t + 1, 64'h055);
    expect_sig("step_en_first", S_EN, t + 1, 64'd1);
    expect_sig("step_halt_first", S_HALT, t + 1, 64'd0);
    expect_sig("step_en_last", S_EN, t + 7, 64'd1);
    expect_done(t + 7);
    expect_sig("step_en_after", S_EN, t + 8, 64'd0);
    expect_sig("step_halt_after", S_HALT, t + 8, 64'd1);
    expect_sig("step_led_lat", S_LED, t + 8, 64'h055);
    expect_sig("step_led", S_LED, t + 9, 64'h1EF);
    expect_sig("step_hex", S_HEX, t + 9, 64'({7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}));
    wait_cyc(1);
    step_req = 1'b0;
    wait_cyc(11);

    // Page and display select
    t = cyc;
    page = 1'b1;
    expect_sig("page1_ch_hex", S_HEX, t + 1, 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40}));
    wait_cyc(1);
    disp_sel = 1'b1;
    expect_sig("page1_st_hex", S_HEX, t + 2, 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h00, 7'h40}));
    wait_cyc(1);
    page = 1'b0;
    disp_sel = 1'b0;
    wait_cyc(2);

    // Free run for 20 cycles, then stop at the next boundary
    t = cyc;
    run_mode = 1'b1;
    expect_done(t + 7);
    expect_done(t + 14);
    expect_done(t + 21);
    expect_sig("run_en_first", S_EN, t + 1, 64'd1);
    expect_sig("run_halt_mid", S_HALT, t + 8, 64'd0);
    expect_sig("run_en_drop", S_EN, t + 20, 64'd1);
    expect_sig("run_en_bound", S_EN, t + 21, 64'd1);
    expect_sig("run_en_stop", S_EN, t + 22, 64'd0);
    expect_sig("run_halt_stop", S_HALT, t + 22, 64'd1);
    wait_cyc(20);
    run_mode = 1'b0;
    wait_cyc(4);

    // Breakpoint on the 2nd boundary, then step with run_mode falling the same cycle
    t = cyc;
    brk_arm  = 1'b1;
    brk_addr = 32'h8;
    pc_in    = 32'h0;
    run_mode = 1'b1;
    expect_done(t + 7);
    expect_done(t + 14);
`ifdef DBG_BREAKPOINT_EN
    expect_done(t + 23);
    expect_sig("brk_en", S_EN, t + 15, 64'd0);
    expect_sig("brk_halt", S_HALT, t + 15, 64'd1);
    expect_sig("brk_step_en", S_EN, t + 23, 64'd1);
`else
    expect_done(t + 21);
    expect_sig("nobrk_en", S_EN, t + 15, 64'd1);
    expect_sig("nobrk_halt", S_HALT, t + 15, 64'd0);
    expect_sig("nobrk_stop_en", S_EN, t + 22, 64'd0);
`endif
    expect_sig("brk_end_en", S_EN, t + 24, 64'd0);
    expect_sig("brk_end_halt", S_HALT, t + 24, 64'd1);
    wait_cyc(8);
    pc_in = 32'h8;
    wait_cyc(8);
    run_mode = 1'b0;
    step_req = 1'b1;
    pc_in    = 32'h9;
    wait_cyc(1);
    step_req = 1'b0;
    wait_cyc(10);
    brk_arm = 1'b0;

    // Reset in cycle 4 of a step abandons the instruction
    t = cyc;
    step_req = 1'b1;
    expect_sig("rstmid_en_pre", S_EN, t + 4, 64'd1);
    expect_sig("rstmid_en", S_EN, t + 5, 64'd0);
    expect_sig("rstmid_done", S_DONE, t + 5, 64'd0);
    expect_sig("rstmid_halt", S_HALT, t + 5, 64'd1);
    expect_sig("rstmid_hex", S_HEX, t + 5, 64'({6{7'h40}}));
    expect_sig("rstmid_led", S_LED, t + 5, 64'd0);
    expect_sig("rstmid_en_hold", S_EN, t + 6, 64'd0);
    expect_sig("rstmid_en_idle", S_EN, t + 9, 64'd0);
    expect_sig("rstmid_halt_idle", S_HALT, t + 9, 64'd1);
    expect_sig("rstmid_led_idle", S_LED, t + 9, 64'd0);
    wait_cyc(1);
    step_req = 1'b0;
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(1);
    ch_sel = 4'd0;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(6);
    fin = 1'b1;
  end

endmodule
